// File: rtl/neuron_argmax_classifier.sv
// Argmax output stage: latches one frame of signed 8.18 neuron scores and scans them
// serially with a single comparator, reporting the winning class on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a frame (in_ready high while out of reset)
// SCAN  | comparing score[ptr] against the running best, one class per cycle
// DONE  | result presented on out_*, held until out_ready
module neuron_argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_WIDTH = 26,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CLASSES*SCORE_WIDTH-1:0] in_scores,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [IDX_WIDTH-1:0]               out_class,
    output logic [SCORE_WIDTH-1:0]             out_score,
    output logic                               out_tie,
    output logic                               out_valid,
    input  logic                               out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SCORE_WIDTH-1:0] score_mem [NUM_CLASSES];
    logic [SCORE_WIDTH-1:0] best;
    logic [SCORE_WIDTH-1:0] cur;
    logic [IDX_WIDTH-1:0]   idx;
    logic [IDX_WIDTH-1:0]   ptr;
    logic                   tie;
    logic                   accept;
    logic                   last;
    logic                   gt;
    logic                   eq;

    assign in_ready = (state == IDLE) && rst;
    assign accept   = in_valid && in_ready;
    assign last     = (ptr == IDX_WIDTH'(NUM_CLASSES - 1));
    assign cur      = score_mem[ptr];
    assign gt       = $signed(cur) > $signed(best);
    assign eq       = (cur == best);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SCAN;
            SCAN: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Scores are copied at acceptance so upstream may change in_scores mid-scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                score_mem[k] <= '0;
            end
            best <= '0;
            idx  <= '0;
            ptr  <= '0;
            tie  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            score_mem[k] <= in_scores[k*SCORE_WIDTH +: SCORE_WIDTH];
                        end
                        best <= in_scores[0 +: SCORE_WIDTH];
                        idx  <= '0;
                        tie  <= 1'b0;
                        ptr  <= IDX_WIDTH'(1);
                    end
                end
                SCAN: begin
                    // Strictly-greater update keeps the lowest index on a tie.
                    if (gt) begin
                        best <= cur;
                        idx  <= ptr;
                        tie  <= 1'b0;
                    end else if (eq) begin
                        tie <= 1'b1;
                    end
                    if (!last) begin
                        ptr <= ptr + IDX_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_class = idx;
    assign out_score = best;
    assign out_tie   = tie;
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_neuron_argmax_classifier.sv
// Directed bench for neuron_argmax_classifier: hand-computed frames covering signed
// compare, ties, latency, backpressure, mid-scan reset and input isolation.
module tb_neuron_argmax_classifier;

    localparam int NC = 10;
    localparam int SW = 26;
    localparam int IW = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NC*SW-1:0]   in_scores;
    logic               in_valid;
    logic               in_ready;
    logic [IW-1:0]      out_class;
    logic [SW-1:0]      out_score;
    logic               out_tie;
    logic               out_valid;
    logic               out_ready;

    int total = 0;
    int bad   = 0;
    int sv [NC];

    neuron_argmax_classifier #(
        .NUM_CLASSES(NC),
        .SCORE_WIDTH(SW),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_scores(in_scores),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_class(out_class),
        .out_score(out_score),
        .out_tie  (out_tie),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NC*SW-1:0] pack_sv();
        logic [NC*SW-1:0] r;
        r = '0;
        for (int k = 0; k < NC; k++) begin
            r[k*SW +: SW] = SW'(sv[k]);
        end
        return r;
    endfunction

    task automatic fill(input int v);
        for (int k = 0; k < NC; k++) sv[k] = v;
    endtask

    task automatic accept_frame(input string tag);
        @(negedge clk);
        in_scores = pack_sv();
        in_valid  = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, in_ready, 0);
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, 9);
    endtask

    task automatic check_result(input string tag, input int cls, input logic [SW-1:0] sc,
                                input logic tie);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_class"}, out_class, cls);
        check({tag, "_score"}, out_score, sc);
        check({tag, "_tie"}, out_tie, tie);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_scores = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_class", out_class, 0);
        check("rst_score", out_score, 0);
        check("rst_tie", out_tie, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        // distinct positive maximum
        for (int k = 0; k < NC; k++) sv[k] = k << 18;
        sv[6] = 100 << 18;
        accept_frame("t1");
        wait_result("t1");
        check_result("t1", 6, 26'd26214400, 1'b0);
        handshake("t1");

        // all negative, signed compare required
        fill(-(5 << 18));
        sv[3] = -(1 << 17);
        accept_frame("t2");
        wait_result("t2");
        check_result("t2", 3, 26'h3FE0000, 1'b0);
        handshake("t2");

        // tie: lowest index wins
        fill(0);
        sv[2] = 3 << 18;
        sv[8] = 3 << 18;
        accept_frame("t3");
        wait_result("t3");
        check_result("t3", 2, 26'd786432, 1'b1);
        handshake("t3");

        // backpressure with frame 2 waiting on in_valid
        fill(1 << 18);
        sv[4] = 20 << 18;
        accept_frame("t4");
        wait_result("t4");
        check_result("t4", 4, 26'd5242880, 1'b0);
        fill(-2);
        sv[0] = -1;
        @(negedge clk);
        in_scores = pack_sv();
        in_valid  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_class", out_class, 4);
            check("t4_hold_score", out_score, 26'd5242880);
            check("t4_hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("t4_hs_valid", out_valid, 0);
        check("t4_hs_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t4b_accepted", in_ready, 0);
        wait_result("t4b");
        check_result("t4b", 0, 26'h3FFFFFF, 1'b0);
        handshake("t4b");

        // reset four cycles into a scan
        fill(0);
        sv[7] = 1 << 18;
        accept_frame("t5");
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_in_ready", in_ready, 0);
        check("t5_rst_class", out_class, 0);
        check("t5_rst_score", out_score, 0);
        check("t5_rst_tie", out_tie, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rel_in_ready", in_ready, 1);
        fill(0);
        sv[5] = 1966080;
        accept_frame("t5b");
        wait_result("t5b");
        check_result("t5b", 5, 26'd1966080, 1'b0);
        handshake("t5b");

        // inputs change after acceptance; max in last class
        fill(1 << 18);
        sv[9] = 50 << 18;
        accept_frame("t6");
        fill(0);
        sv[0] = 127 << 18;
        in_scores = pack_sv();
        wait_result("t6");
        check_result("t6", 9, 26'd13107200, 1'b0);
        handshake("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
